// File: rtl/pdm_stream_serializer.sv
// Word FIFO feeding a gapless serial audio shifter.
// Bit timing comes from a clock-enable strobe in the clock_i domain.
module pdm_stream_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 100,
  parameter int FIFO_DEPTH = 4,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 enable_i,
  input  logic [DATA_WIDTH-1:0]                data_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level_o,
  output logic                                 pdm_audio_o,
  output logic                                 pdm_sdaudio_o,
  output logic                                 done_o,
  output logic                                 underrun_o
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [TW-1:0]         timer;
  logic                  tick;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;

  state_t                state;
  state_t                state_n;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_n;
  logic [CW-1:0]         bitcnt;
  logic [CW-1:0]         bitcnt_n;
  logic                  armed;
  logic                  armed_n;
  logic                  audio_n;
  logic                  done_n;
  logic                  underrun_n;
  logic                  load;

  function automatic logic first_bit(
    input logic [DATA_WIDTH-1:0] w
  );
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(
    input logic [DATA_WIDTH-1:0] w
  );
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign tick    = enable_i && (timer == TW'(CLK_DIV - 1));
  assign ready_o = (level != LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push    = valid_i && ready_o;
  assign head    = mem[rd_ptr];
  assign level_o = level;

  always_ff @(posedge clock_i) begin
    if (reset_i || !enable_i || tick) timer <= '0;
    else                              timer <= timer + 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bitcnt_n   = bitcnt;
    armed_n    = armed;
    audio_n    = pdm_audio_o;
    done_n     = 1'b0;
    underrun_n = underrun_o;
    load       = 1'b0;
    pop        = 1'b0;
    if (!enable_i) begin
      state_n    = IDLE;
      bitcnt_n   = '0;
      armed_n    = 1'b0;
      audio_n    = IDLE_LEVEL;
      underrun_n = 1'b0;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            load = 1'b1;
          end else begin
            audio_n = IDLE_LEVEL;
            if (armed) underrun_n = 1'b1;
          end
        end
        SHIFT: begin
          if (bitcnt != CW'(DATA_WIDTH - 1)) begin
            audio_n  = first_bit(shreg);
            shreg_n  = advance(shreg);
            bitcnt_n = bitcnt + 1'b1;
          end else begin
            done_n = 1'b1;
            if (!empty) begin
              load = 1'b1;
            end else begin
              audio_n    = IDLE_LEVEL;
              underrun_n = 1'b1;
              state_n    = IDLE;
            end
          end
        end
      endcase
      // Next word starts on this tick so the line never gaps.
      if (load) begin
        pop      = 1'b1;
        audio_n  = first_bit(head);
        shreg_n  = advance(head);
        bitcnt_n = '0;
        armed_n  = 1'b1;
        state_n  = SHIFT;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= IDLE;
      shreg         <= '0;
      bitcnt        <= '0;
      armed         <= 1'b0;
      pdm_audio_o   <= IDLE_LEVEL;
      pdm_sdaudio_o <= 1'b0;
      done_o        <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      state         <= state_n;
      shreg         <= shreg_n;
      bitcnt        <= bitcnt_n;
      armed         <= armed_n;
      pdm_audio_o   <= audio_n;
      pdm_sdaudio_o <= enable_i;
      done_o        <= done_n;
      underrun_o    <= underrun_n;
    end
  end

endmodule
